multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the RV32I core. A single FSM steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It handshakes with instruction and data memory, and it issues the per-state enables for the PC, instruction register, register file and data memory. It also generates the 2-bit `U_control` select that the upper-immediate/jump datapath consumes. A memory wait watchdog and an optional illegal-opcode trap move the FSM into a terminal TRAP state.

## Interface
Parameters:
- `WAIT_MAX`, default 15: maximum tolerated consecutive memory wait cycles. Must be ≥1. The wait counter is `$clog2(WAIT_MAX+1)` bits wide.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  reset; asynchronous, active-high
- `opcode_in`  in  7  opcode field from the instruction register; valid from DECODE onward
- `imem_ready`  in  1  instruction memory has data this cycle
- `dmem_ready`  in  1  data memory access completes this cycle
- `imem_req`  out  1  instruction fetch request
- `ir_we`  out  1  instruction register load
- `pc_we`  out  1  PC update (commit)
- `dmem_req`  out  1  data memory request
- `dmem_we`  out  1  data memory write (stores)
- `rf_we`  out  1  register file write
- `alu_src_imm`  out  1  ALU operand B is the immediate
- `U_control`  out  2  JAL/JALR=00, LUI=01, AUIPC=10, all other opcodes=00
- `instr_done`  out  1  one-cycle pulse when an instruction retires
- `trap`  out  1  sticky; the FSM is in TRAP
- `trap_cause`  out  2  00 none, 01 illegal opcode, 10 memory timeout

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Opcode register `op_q` (7 bits) is loaded from `opcode_in` in DECODE.
- `U_control` and `alu_src_imm` decode from `op_q`.
- Legal opcodes:
  - LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, BRANCH 1100011
  - JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111
- FETCH: `imem_req`=1.
  - `imem_ready`=1 → `ir_we`=1 in the same cycle; next state is DECODE.
- DECODE: latch `op_q`.
  - Illegal opcode with the trap feature enabled → TRAP, `trap_cause`=01.
  - Otherwise → EXEC.
- EXEC: `alu_src_imm`=1 for OP-IMM, LOAD, STORE and JALR.
  - LOAD/STORE → MEM.
  - BRANCH → FETCH, with `pc_we`=1 and `instr_done`=1.
  - Illegal opcode with the trap feature compiled out → FETCH, with `pc_we`=1 and `instr_done`=1 (executes as a NOP).
  - All other opcodes → WB.
- MEM: `dmem_req`=1; `dmem_we`=1 only for STORE.
  - On `dmem_ready`: STORE → FETCH, with `pc_we`=1 and `instr_done`=1.
  - On `dmem_ready`: LOAD → WB.
- WB: `rf_we`=1, `pc_we`=1, `instr_done`=1; next state is FETCH.
- Watchdog:
  - The counter clears on entry to FETCH or MEM.
  - It increments each FETCH/MEM cycle with ready low.
  - Ready low while counter==`WAIT_MAX` → TRAP, `trap_cause`=10.
- TRAP: terminal until `rst`.
  - All enables and requests are 0; `trap`=1; `trap_cause` holds its value.

## Timing
- Reset:
  - `rst` asserted: state=FETCH, `op_q`=0, counter=0, `trap_cause`=00.
  - Every output is 0 while `rst` is high, including `imem_req`, which is gated by `rst`.
  - `imem_req` rises in the first cycle after `rst` deasserts.
- Output timing:
  - `ir_we`, `pc_we` and `instr_done` are combinational from state plus the ready input (Mealy).
  - All other outputs depend only on state and `op_q` (Moore).
- Latency with zero wait states, counted from the first FETCH cycle to the `instr_done` cycle inclusive:
  - BRANCH: 3 cycles
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, STORE: 4 cycles
  - LOAD: 5 cycles
- Each memory wait cycle adds one cycle of latency.
- Ready sampled high in the same cycle the counter reaches `WAIT_MAX`: ready wins, with no trap.
- `rst` asserted mid-instruction: the FSM aborts immediately to FETCH. There is no partial commit; `pc_we`, `rf_we` and `dmem_we` are 0 from the asserting edge.
- Ready inputs are ignored in states other than FETCH and MEM.

## Configuration
- `MULTICYCLE_ILLEGAL_TRAP_EN`
  - Defined: illegal opcodes in DECODE enter TRAP with `trap_cause`=01.
  - Undefined: illegal opcodes retire as NOP through EXEC (PC advances, no register file or memory write), and `trap_cause` never takes the value 01.
- The watchdog is always present.

## Test plan
- LUI (0110111), `imem_ready` held high → DECODE, EXEC, WB follow FETCH; `U_control`=01 from EXEC; `rf_we`=1 and `instr_done`=1 at cycle 4.
- LOAD, `dmem_ready` low for 3 cycles in MEM → `dmem_req`=1 for 4 cycles; WB on cycle 8; `trap`=0.
- STORE, `dmem_ready` high immediately → `dmem_we`=1 for 1 cycle; `pc_we`=1 and `instr_done`=1 in MEM; `rf_we` never asserted.
- `imem_ready` held low with `WAIT_MAX`=15 → TRAP after 16 FETCH cycles; `trap_cause`=10. Repeat with ready high on the 16th cycle → DECODE, no trap.
- Opcode 1111111 → with macro: TRAP, `trap_cause`=01. Without macro: NOP retire at cycle 3 with `pc_we`=1 and `rf_we`=0.
- `rst` pulsed during MEM of a STORE → `dmem_we` drops asynchronously; after release `imem_req`=1 and state is FETCH; `instr_done` is not pulsed.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core, with a memory wait watchdog.
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they retire as a NOP.
module multicycle_ctrl #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode_in,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_we,
    output logic       pc_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       rf_we,
    output logic       alu_src_imm,
    output logic [1:0] U_control,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);
    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    state_t          r_state;
    logic [6:0]      r_op;
    logic [CW-1:0]   r_wait;
    logic [1:0]      r_cause;

    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_branch;
    logic            w_op_legal;
    logic            w_wait_expired;

    function automatic logic f_legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_OP, OP_OPIMM, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] f_u_sel(input logic [6:0] op);
        case (op)
            OP_LUI:   return 2'b01;
            OP_AUIPC: return 2'b10;
            default:  return 2'b00;
        endcase
    endfunction

    assign w_is_load      = (r_op == OP_LOAD);
    assign w_is_store     = (r_op == OP_STORE);
    assign w_is_branch    = (r_op == OP_BRANCH);
    assign w_op_legal     = f_legal(r_op);
    assign w_wait_expired = (r_wait == WAIT_LIM);

    // Counter is cleared on every transition into FETCH or MEM so each wait window starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_wait  <= '0;
            r_cause <= 2'b00;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_wait_expired) begin
                        r_state <= S_TRAP;
                        r_cause <= CAUSE_TIMEOUT;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                S_DECODE: begin
                    r_op <= opcode_in;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    if (!f_legal(opcode_in)) begin
                        r_state <= S_TRAP;
                        r_cause <= CAUSE_ILLEGAL;
                    end else begin
                        r_state <= S_EXEC;
                    end
`else
                    r_state <= S_EXEC;
`endif
                end
                S_EXEC: begin
                    if (w_is_load || w_is_store) begin
                        r_state <= S_MEM;
                        r_wait  <= '0;
                    end else if (w_is_branch || !w_op_legal) begin
                        r_state <= S_FETCH;
                        r_wait  <= '0;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (w_is_store) begin
                            r_state <= S_FETCH;
                            r_wait  <= '0;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (w_wait_expired) begin
                        r_state <= S_TRAP;
                        r_cause <= CAUSE_TIMEOUT;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_wait  <= '0;
                end
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Commit strobes are Mealy on the ready inputs; everything is forced low while rst is high.
    always_comb begin
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        alu_src_imm = 1'b0;
        instr_done  = 1'b0;
        trap        = 1'b0;
        U_control   = 2'b00;
        trap_cause  = 2'b00;
        if (!rst) begin
            U_control  = f_u_sel(r_op);
            trap_cause = r_cause;
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_EXEC: begin
                    alu_src_imm = (r_op == OP_OPIMM) || w_is_load || w_is_store || (r_op == OP_JALR);
                    if (w_is_branch || !w_op_legal) begin
                        pc_we      = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = w_is_store;
                    if (dmem_ready && w_is_store) begin
                        pc_we      = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_WB: begin
                    rf_we      = 1'b1;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                end
                S_TRAP:  trap = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction phase plans drive stimulus and predict every output cycle.
module tb_multicycle_ctrl;
    localparam int WM = 15;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPR    = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode_in = '0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, ir_we, pc_we, dmem_req, dmem_we, rf_we, alu_src_imm;
    logic [1:0] U_control;
    logic       instr_done, trap;
    logic [1:0] trap_cause;

    multicycle_ctrl #(.WAIT_MAX(WM)) dut (
        .clk(clk), .rst(rst), .opcode_in(opcode_in),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we),
        .alu_src_imm(alu_src_imm), .U_control(U_control),
        .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       pc_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       rf_we;
        logic       alu_src_imm;
        logic [1:0] uc;
        logic       instr_done;
        logic       trap;
        logic [1:0] cause;
    } outs_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         icyc, done_at, done_n, dreq_n, dwe_n, rfwe_n, ireq_n;
    bit         trapped;
    logic [1:0] tcause;

    function automatic bit legal(input logic [6:0] op);
        return op inside {LOAD, STORE, OPR, OPIMM, BRANCH, JAL, JALR, LUI, AUIPC};
    endfunction

    function automatic logic [1:0] uc_of(input logic [6:0] op);
        return (op == LUI) ? 2'b01 : (op == AUIPC) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic imm_of(input logic [6:0] op);
        return op inside {OPIMM, LOAD, STORE, JALR};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] r7();
        return 7'($urandom);
    endfunction

    function automatic outs_t sample();
        outs_t a;
        a.imem_req = imem_req; a.ir_we = ir_we; a.pc_we = pc_we;
        a.dmem_req = dmem_req; a.dmem_we = dmem_we; a.rf_we = rf_we;
        a.alu_src_imm = alu_src_imm; a.uc = U_control;
        a.instr_done = instr_done; a.trap = trap; a.cause = trap_cause;
        return a;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // One clock: apply inputs just after the rising edge, compare all outputs at the falling edge.
    task automatic drive(input logic imr, input logic dmr, input logic [6:0] opc,
                         input outs_t e, input bit ucare, input string tag);
        outs_t a, m;
        imem_ready = imr;
        dmem_ready = dmr;
        opcode_in  = opc;
        icyc++;
        @(negedge clk);
        a = sample();
        m = '1;
        if (!ucare) m.uc = 2'b00;
        n_tests++;
        if ((a & m) !== (e & m)) begin
            n_fail++;
            $display("FAIL %s cyc%0d: got %b, want %b (mask %b)", tag, icyc, a, e, m);
        end
        if (a.instr_done === 1'b1) begin done_n++; done_at = icyc; end
        if (a.dmem_req === 1'b1) dreq_n++;
        if (a.dmem_we === 1'b1) dwe_n++;
        if (a.rf_we === 1'b1) rfwe_n++;
        if (a.imem_req === 1'b1) ireq_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_instr();
        icyc = 0; done_at = 0; done_n = 0; dreq_n = 0;
        dwe_n = 0; rfwe_n = 0; ireq_n = 0; trapped = 0;
    endtask

    task automatic do_reset();
        outs_t z;
        z = '0;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) drive(rb(), rb(), r7(), z, 1'b1, "reset");
        rst = 1'b0;
    endtask

    task automatic trap_hold(input int n);
        outs_t e;
        e = '0;
        e.trap = 1'b1;
        e.cause = tcause;
        for (int i = 0; i < n; i++) drive(rb(), rb(), r7(), e, 1'b0, "trap");
    endtask

    // Expected behaviour of one instruction with fw fetch waits and mw memory waits.
    task automatic do_instr(input logic [6:0] op, input int fw, input int mw);
        outs_t e;
        bit    isl;
        bit    ismem;
        isl     = legal(op);
        ismem   = (op == LOAD) || (op == STORE);
        trapped = 0;
        for (int i = 0; i <= WM; i++) begin
            e = '0;
            e.imem_req = 1'b1;
            e.ir_we    = (i == fw);
            drive((i == fw), rb(), r7(), e, 1'b0, "fetch");
            if (i == fw) break;
        end
        if (fw > WM) begin trapped = 1; tcause = 2'b10; return; end
        e = '0;
        drive(rb(), rb(), op, e, 1'b0, "decode");
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        if (!isl) begin trapped = 1; tcause = 2'b01; return; end
`endif
        e = '0;
        e.alu_src_imm = imm_of(op);
        e.uc = uc_of(op);
        if (op == BRANCH || !isl) begin
            e.pc_we = 1'b1;
            e.instr_done = 1'b1;
            drive(rb(), rb(), r7(), e, 1'b1, "exec");
            return;
        end
        drive(rb(), rb(), r7(), e, 1'b1, "exec");
        if (ismem) begin
            for (int i = 0; i <= WM; i++) begin
                e = '0;
                e.dmem_req = 1'b1;
                e.dmem_we  = (op == STORE);
                e.uc = uc_of(op);
                if (i == mw && op == STORE) begin
                    e.pc_we = 1'b1;
                    e.instr_done = 1'b1;
                end
                drive(rb(), (i == mw), r7(), e, 1'b1, "mem");
                if (i == mw) break;
            end
            if (mw > WM) begin trapped = 1; tcause = 2'b10; return; end
            if (op == STORE) return;
        end
        e = '0;
        e.rf_we = 1'b1;
        e.pc_we = 1'b1;
        e.instr_done = 1'b1;
        e.uc = uc_of(op);
        drive(rb(), rb(), r7(), e, 1'b1, "wb");
    endtask

    initial begin
        logic [6:0] table_ops [9];
        logic [6:0] op;
        outs_t      e;
        int         fw, mw;
        table_ops = '{LOAD, STORE, OPR, OPIMM, BRANCH, JAL, JALR, LUI, AUIPC};

        do_reset();

        begin_instr(); do_instr(LUI, 0, 0);
        check("lui_done_cycle", done_at, 4);
        check("lui_rf_we_cycles", rfwe_n, 1);

        begin_instr(); do_instr(LOAD, 0, 3);
        check("load_wait3_done_cycle", done_at, 8);
        check("load_wait3_dmem_req_cycles", dreq_n, 4);
        check("load_wait3_trap", int'(trap), 0);

        begin_instr(); do_instr(STORE, 0, 0);
        check("store_done_cycle", done_at, 4);
        check("store_dmem_we_cycles", dwe_n, 1);
        check("store_rf_we_cycles", rfwe_n, 0);

        begin_instr(); do_instr(BRANCH, 0, 0);
        check("branch_done_cycle", done_at, 3);

        begin_instr(); do_instr(OPR, 16, 0);
        check("fetch_timeout_trapped", int'(trapped), 1);
        check("fetch_timeout_req_cycles", ireq_n, 16);
        trap_hold(3);
        check("fetch_timeout_cause", int'(trap_cause), 2);
        do_reset();

        begin_instr(); do_instr(OPR, 15, 0);
        check("fetch_ready_at_limit_trapped", int'(trapped), 0);
        check("fetch_ready_at_limit_done", done_at, 19);

        begin_instr(); do_instr(LOAD, 0, 16);
        check("mem_timeout_trapped", int'(trapped), 1);
        trap_hold(2);
        check("mem_timeout_cause", int'(trap_cause), 2);
        do_reset();

        begin_instr(); do_instr(LOAD, 0, 15);
        check("mem_ready_at_limit_done", done_at, 20);

        begin_instr(); do_instr(7'b1111111, 0, 0);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        check("illegal_trapped", int'(trapped), 1);
        trap_hold(2);
        check("illegal_cause", int'(trap_cause), 1);
        do_reset();
`else
        check("illegal_nop_done_cycle", done_at, 3);
        check("illegal_nop_rf_we_cycles", rfwe_n, 0);
`endif

        // Reset asserted in the middle of a STORE's memory wait.
        begin_instr();
        e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1;
        drive(1'b1, 1'b0, r7(), e, 1'b0, "rst_fetch");
        e = '0;
        drive(1'b0, 1'b0, STORE, e, 1'b0, "rst_decode");
        e = '0; e.alu_src_imm = 1'b1;
        drive(1'b0, 1'b0, r7(), e, 1'b1, "rst_exec");
        e = '0; e.dmem_req = 1'b1; e.dmem_we = 1'b1;
        drive(1'b0, 1'b0, r7(), e, 1'b1, "rst_mem");
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check("mid_mem_dmem_we_before_rst", int'(dmem_we), 1);
        rst = 1'b1;
        #1;
        check("mid_mem_dmem_we_after_rst", int'(dmem_we), 0);
        check("mid_mem_pc_we_after_rst", int'(pc_we), 0);
        check("mid_mem_imem_req_in_rst", int'(imem_req), 0);
        e = '0;
        drive(1'b0, 1'b1, r7(), e, 1'b1, "rst_hold");
        rst = 1'b0;
        check("mid_mem_no_retire", done_n, 0);
        begin_instr(); do_instr(OPIMM, 0, 0);
        check("after_rst_done_cycle", done_at, 4);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = r7(); while (legal(op));
            end else begin
                op = table_ops[$urandom_range(0, 8)];
            end
            fw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 2));
            begin_instr();
            do_instr(op, fw, mw);
            if (trapped) begin
                trap_hold(2);
                do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
